// File: rtl/fifo_uart_tx_if.sv
// Read-port bundle between a first-word-fall-through byte FIFO and its UART drain.
// master = FIFO side (presents head word), slave = drain side (issues pops).
interface fifo_uart_tx_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_deq;

    modport master (
        output fifo_empty,
        output fifo_data,
        input  fifo_deq
    );

    modport slave (
        input  fifo_empty,
        input  fifo_data,
        output fifo_deq
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a fall-through FIFO and shifts each out as a start/data(LSB first)/stop
// serial frame; tx and done are registered, fifo_deq is the only combinational output.
module fifo_uart_tx #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    fifo_uart_tx_if.slave fifo,
    output logic          tx,
    output logic          busy,
    output logic          done
);
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic [BAUD_W-1:0]     r_baud,  w_baud_nxt;
    logic [IDX_W-1:0]      r_idx,   w_idx_nxt;
    logic                  r_tx,    w_tx_nxt;
    logic                  r_done,  w_done_nxt;
    logic                  w_deq;
    logic                  w_bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_baud  <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_baud  <= w_baud_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_deq       = (r_state == IDLE) && !fifo.fifo_empty && !rst;
        w_bit_end   = (r_baud == BAUD_LAST);
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_baud_nxt  = r_baud + BAUD_W'(1);
        w_idx_nxt   = r_idx;
        w_tx_nxt    = r_tx;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                if (w_deq) begin
                    w_shreg_nxt = fifo.fifo_data;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_tx_nxt    = r_shreg[0];
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                // tx is loaded with the bit that becomes shreg[0] after this shift
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_shreg_nxt = r_shreg >> 1;
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_tx_nxt    = w_shreg_nxt[0];
                    if (r_idx == IDX_LAST) begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign fifo.fifo_deq = w_deq;
    assign tx            = r_tx;
    assign done          = r_done;
    assign busy          = (r_state != IDLE);
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Drain-side companion to the bus byte FIFO. It pops bytes from a first-word-fall-through FIFO and shifts each one out as an 8N1-style asynchronous serial frame on a single line: start bit, DATA_WIDTH data bits LSB first, one stop bit. It sits between the FIFO read port (`empty`/`deq`/`data_out`) and the serial pin, and runs continuously while the FIFO holds data.

## Interface
- `DATA_WIDTH`, 8: frame data bits; must match the FIFO width.
- `CLKS_PER_BIT`, 16: clk cycles per serial bit; legal range ≥ 2.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag; `fifo_data` is valid when low.
- `fifo_data`  in  DATA_WIDTH  FIFO head word (fall-through).
- `fifo_deq`  out  1  pop strobe to the FIFO; one cycle per byte.
- `tx`  out  1  serial line; idles high; registered.
- `busy`  out  1  high while a frame is in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse after each stop bit completes; registered.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- Datapath registers:
  - shift register, DATA_WIDTH bits.
  - baud counter, $clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1.
  - bit index, $clog2(DATA_WIDTH) bits, minimum 1 bit.
- IDLE:
  - `fifo_deq` = (state==IDLE) & !fifo_empty & !rst. This is the only combinational output.
  - On an edge with `fifo_deq` high: shift register ← `fifo_data`, counters ← 0, `tx` ← 0, state → START.
  - The FIFO pops on the same edge.
- START:
  - Hold `tx`=0 for CLKS_PER_BIT cycles.
  - On the last cycle: `tx` ← shreg[0], state → DATA.
- DATA:
  - Each bit is held CLKS_PER_BIT cycles.
  - At each bit end: shift right, bit index +1, `tx` ← next bit.
  - After bit DATA_WIDTH-1: `tx` ← 1, state → STOP.
- STOP:
  - Hold `tx`=1 for CLKS_PER_BIT cycles.
  - On the last cycle: state → IDLE, `done` ← 1 for exactly one cycle.
- `fifo_empty` and `fifo_data` are ignored outside IDLE.
- A byte is consumed only via `fifo_deq`. No re-read and no double pop.
- Reset values: state IDLE, `tx`=1, `busy`=0, `done`=0, `fifo_deq`=0, all counters and the shift register 0.

## Timing
- Let C = CLKS_PER_BIT, W = DATA_WIDTH. Cycle 0 is the cycle in which `fifo_deq` is high.
  - `tx`=0 in cycles 1..C.
  - Data bit i in cycles C·(i+1)+1 .. C·(i+2).
  - Stop bit in cycles C·(W+1)+1 .. C·(W+2).
  - `done`=1 and state=IDLE in cycle C·(W+2)+1.
- Back-to-back: if the FIFO is non-empty in the IDLE cycle in which `done` is high, `fifo_deq` asserts in that same cycle.
  - Frame period is exactly C·(W+2)+1 cycles.
  - The line stays high for C+1 cycles between frames (stop bit plus one IDLE cycle).
- `busy` rises in cycle 1 and falls in cycle C·(W+2)+1.
- Reset mid-frame: the next cycle shows `tx`=1, `busy`=0, state IDLE. The in-flight byte is lost because it was already popped.
- `fifo_deq` is held low in any cycle with `rst`=1, even if the FIFO is non-empty.
- The first pop can occur in the first cycle after `rst` deasserts.

## Test plan
- **Reset values:** hold `rst` 3 cycles with `fifo_empty`=0 → `tx`=1, `busy`=0, `done`=0, `fifo_deq`=0 throughout.
- **Single byte (W=8, C=4):** present 0xA5, `fifo_empty`=0 for one pop.
  - `fifo_deq` high exactly 1 cycle.
  - `tx` sampled mid-bit = 0, 1,0,1,0,0,1,0,1, 1.
  - `done` pulses at cycle 41.
  - `busy` high cycles 1–40.
- **Back-to-back:** FIFO preloaded with 0x00, 0xFF, 0x5A.
  - Exactly 3 `fifo_deq` pulses, spaced 41 cycles apart.
  - Decoded bytes arrive in the same order.
  - `busy` low only 1 cycle between frames.
- **Empty FIFO:** `fifo_empty`=1 for 200 cycles → no `fifo_deq`, `tx`=1, `busy`=0; `fifo_data` changes have no effect.
- **Reset mid-frame:** assert `rst` during data bit 3 with the FIFO non-empty.
  - `tx`=1 and `busy`=0 the next cycle.
  - No `fifo_deq` while `rst` is high.
  - After release, the next byte transmits correctly.
- **With the FIFO (DEPTH=16, C=2):** enqueue 5 random bytes while a frame is in flight → the serial decoder recovers all 5 in order, and the FIFO `empty` flag rises after the 5th pop.
